// File: rtl/multi_stream_engine_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multi_stream_engine_ctrl_package
// Shared types for the multi-stream engine control core:
//   state_e  - job sequencing states (IDLE, RUN, WAIT, DONE)
//   ctrl_t   - control request bundle (start, clear, len)
//   flags_t  - status flag bundle (ready, done, busy, err)
//   CNT_W_DEFAULT - default width of beat counters and the length field
// ----------------------------------------------------------------------------
package multi_stream_engine_ctrl_package;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic                     start;
        logic                     clear;
        logic [CNT_W_DEFAULT-1:0] len;
    } ctrl_t;

    typedef struct packed {
        logic ready;
        logic done;
        logic busy;
        logic err;
    } flags_t;

endpackage

// File: rtl/multi_stream_engine_ctrl_stream_beat_counter.sv
// ----------------------------------------------------------------------------
// stream_beat_counter
// Counts valid&ready handshakes on one stream while enabled.
// With HAS_LIMIT set the count stops at limit_i: the channel reports complete
// once the count equals the limit, and any further beat is flagged as overrun
// while the count holds. Without a limit the count wraps freely.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           count beats this cycle
//   clr_i          synchronous zero of the count (wins over en_i)
//   valid_i/ready_i stream handshake
//   limit_i        expected beat count (ignored without HAS_LIMIT)
//   cnt_o          current beat count
//   complete_o     count has reached the limit
//   overrun_o      a counted beat arrived on a complete channel this cycle
// ----------------------------------------------------------------------------
module stream_beat_counter #(
    parameter int CNT_W     = 32,
    parameter bit HAS_LIMIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             complete_o,
    output logic             overrun_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat;

    assign beat       = en_i & valid_i & ready_i;
    assign complete_o = HAS_LIMIT ? (cnt_q == limit_i) : 1'b0;
    assign overrun_o  = beat & complete_o;
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (beat && !complete_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_stream_engine_ctrl.sv
// ----------------------------------------------------------------------------
// multi_stream_engine_ctrl
// Control core between the HWPE control FSM and the kernel adapter. Starts the
// kernel, counts handshakes on N_IN sink and N_OUT source streams, checks every
// output channel against a length latched at start, flags overruns and raises
// a one-cycle done once all outputs are complete and the kernel has finished.
// Optional feature macro: MULTI_STREAM_ENGINE_CTRL_PERF_EN enables the
// active-cycle and output-stall counters; otherwise those ports read 0.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             synchronous clear back to IDLE, counters/flags zeroed
//   start_i, len_i      job request and expected beats per output channel
//   k_ready_i, k_idle_i, k_done_i  kernel status
//   in_valid_i/in_ready_i, out_valid_i/out_ready_i  per-channel handshakes
//   k_start_o           one-cycle kernel start pulse
//   busy_o, ready_o, done_o, err_o  status flags
//   out_cnt_o, in_cnt_o per-channel beat counts (channel i at [i*CNT_W +: CNT_W])
//   strb_o              output strobes, all ones
//   perf_cyc_o, perf_stall_o  performance counters
// ----------------------------------------------------------------------------
module multi_stream_engine_ctrl
    import multi_stream_engine_ctrl_package::*;
#(
    parameter int N_IN   = 1,
    parameter int N_OUT  = 1,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int STRB_W = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        len_i,
    input  logic                    k_ready_i,
    input  logic                    k_idle_i,
    input  logic                    k_done_i,
    input  logic [N_IN-1:0]         in_valid_i,
    input  logic [N_IN-1:0]         in_ready_i,
    input  logic [N_OUT-1:0]        out_valid_i,
    input  logic [N_OUT-1:0]        out_ready_i,
    output logic                    k_start_o,
    output logic                    busy_o,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [N_OUT*CNT_W-1:0]  out_cnt_o,
    output logic [N_IN*CNT_W-1:0]   in_cnt_o,
    output logic [N_OUT*STRB_W-1:0] strb_o,
    output logic [CNT_W-1:0]        perf_cyc_o,
    output logic [CNT_W-1:0]        perf_stall_o
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             kdone_q, kdone_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic             active;
    logic             start_acc;
    logic             cnt_clr;
    logic             all_complete;
    logic             kdone_seen;
    logic [N_OUT-1:0] out_complete;
    logic [N_OUT-1:0] out_overrun;
    logic [N_IN-1:0]  in_complete_unused;
    logic [N_IN-1:0]  in_overrun_unused;
    flags_t           flags;

    assign active       = (state_q == RUN) || (state_q == WAIT);
    // clear_i beats a simultaneous start request
    assign start_acc    = ~clear_i & start_i & ready_q & (state_q == IDLE);
    assign cnt_clr      = clear_i | start_acc;
    assign all_complete = &out_complete;
    // a done pulse arriving in the completing cycle counts immediately
    assign kdone_seen   = kdone_q | k_done_i;

    always_comb begin
        state_d = state_q;
        ready_d = (state_q == IDLE) & (k_ready_i | k_idle_i);
        err_d   = err_q | (|out_overrun);
        kdone_d = kdone_q | (active & k_done_i);
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = RUN;
                    len_d   = len_i;
                    err_d   = 1'b0;
                    kdone_d = 1'b0;
                end
            end
            RUN: begin
                if (all_complete) begin
                    state_d = kdone_seen ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (kdone_seen) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = IDLE;
            ready_d = 1'b0;
            err_d   = 1'b0;
            kdone_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            kdone_q <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            kdone_q <= kdone_d;
            len_q   <= len_d;
        end
    end

    for (genvar c = 0; c < N_OUT; c++) begin : g_out
        stream_beat_counter #(.CNT_W(CNT_W), .HAS_LIMIT(1'b1)) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .en_i       (active),
            .clr_i      (cnt_clr),
            .valid_i    (out_valid_i[c]),
            .ready_i    (out_ready_i[c]),
            .limit_i    (len_q),
            .cnt_o      (out_cnt_o[c*CNT_W +: CNT_W]),
            .complete_o (out_complete[c]),
            .overrun_o  (out_overrun[c])
        );
    end

    for (genvar c = 0; c < N_IN; c++) begin : g_in
        stream_beat_counter #(.CNT_W(CNT_W), .HAS_LIMIT(1'b0)) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .en_i       (active),
            .clr_i      (cnt_clr),
            .valid_i    (in_valid_i[c]),
            .ready_i    (in_ready_i[c]),
            .limit_i    ('0),
            .cnt_o      (in_cnt_o[c*CNT_W +: CNT_W]),
            .complete_o (in_complete_unused[c]),
            .overrun_o  (in_overrun_unused[c])
        );
    end

    assign flags = '{ready: ready_q,
                     done:  (state_q == DONE) & ~clear_i,
                     busy:  active,
                     err:   err_q};

    assign k_start_o = start_acc;
    assign ready_o   = flags.ready;
    assign done_o    = flags.done;
    assign busy_o    = flags.busy;
    assign err_o     = flags.err;
    assign strb_o    = '1;

`ifdef MULTI_STREAM_ENGINE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_cyc_q, perf_cyc_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic             stall;

    assign stall = |(out_valid_i & ~out_ready_i);

    always_comb begin
        perf_cyc_d   = perf_cyc_q;
        perf_stall_d = perf_stall_q;
        if (cnt_clr) begin
            perf_cyc_d   = '0;
            perf_stall_d = '0;
        end else if (active) begin
            if (perf_cyc_q != '1) begin
                perf_cyc_d = perf_cyc_q + CNT_W'(1);
            end
            if (stall && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cyc_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_cyc_q   <= perf_cyc_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_cyc_o   = perf_cyc_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_cyc_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_multi_stream_engine_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multi_stream_engine_ctrl
// Scoreboard bench: the stimulus process advances a job-level reference model
// each cycle and queues the expected kernel-start / job-done pulses together
// with the counts they must carry; a monitor pops and compares whenever the
// DUT pulses k_start_o or done_o. Directed scenarios are followed by random
// traffic.
// ----------------------------------------------------------------------------
module tb_multi_stream_engine_ctrl;

    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam int CNT_W  = 8;
    localparam int STRB_W = 4;
    localparam int CMAX   = 255;
`ifdef MULTI_STREAM_ENGINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    clear_i;
    logic                    start_i;
    logic [CNT_W-1:0]        len_i;
    logic                    k_ready_i;
    logic                    k_idle_i;
    logic                    k_done_i;
    logic [N_IN-1:0]         in_valid_i;
    logic [N_IN-1:0]         in_ready_i;
    logic [N_OUT-1:0]        out_valid_i;
    logic [N_OUT-1:0]        out_ready_i;
    logic                    k_start_o;
    logic                    busy_o;
    logic                    ready_o;
    logic                    done_o;
    logic                    err_o;
    logic [N_OUT*CNT_W-1:0]  out_cnt_o;
    logic [N_IN*CNT_W-1:0]   in_cnt_o;
    logic [N_OUT*STRB_W-1:0] strb_o;
    logic [CNT_W-1:0]        perf_cyc_o;
    logic [CNT_W-1:0]        perf_stall_o;

    multi_stream_engine_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .STRB_W(STRB_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .k_ready_i(k_ready_i), .k_idle_i(k_idle_i),
        .k_done_i(k_done_i), .in_valid_i(in_valid_i), .in_ready_i(in_ready_i),
        .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
        .k_start_o(k_start_o), .busy_o(busy_o), .ready_o(ready_o),
        .done_o(done_o), .err_o(err_o), .out_cnt_o(out_cnt_o),
        .in_cnt_o(in_cnt_o), .strb_o(strb_o), .perf_cyc_o(perf_cyc_o),
        .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int n_start = 0;
    int n_done = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         kind;   // 0 = kernel start, 1 = job done
        int         cyc;
        logic [15:0] ocnt;
        logic [15:0] icnt;
        bit         err;
        int         pc;
        int         ps;
    } ev_t;

    ev_t sbq[$];

    bit m_job;      // a job is running (counting beats)
    bit m_fin;      // job finished, done pulse due this cycle
    bit m_rdy;      // engine-ready as seen this cycle
    bit m_kflag;    // kernel has reported done for the current job
    bit m_err;
    int m_len;
    int m_oc[N_OUT];
    int m_ic[N_IN];
    int m_pc;
    int m_ps;

    task automatic model_reset();
        m_job = 0; m_fin = 0; m_rdy = 0; m_kflag = 0; m_err = 0; m_len = 0;
        m_pc = 0; m_ps = 0;
        for (int c = 0; c < N_OUT; c++) m_oc[c] = 0;
        for (int c = 0; c < N_IN; c++) m_ic[c] = 0;
    endtask

    function automatic ev_t snap(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.ocnt = {8'(m_oc[1]), 8'(m_oc[0])};
        e.icnt = {8'(m_ic[1]), 8'(m_ic[0])};
        e.err  = m_err;
        e.pc   = PERF ? m_pc : 0;
        e.ps   = PERF ? m_ps : 0;
        return e;
    endfunction

    // Consumes the inputs applied for the current cycle and moves the model
    // to its state after the next clock edge.
    task automatic model_eval();
        bit idle, start, all_done, finish, stall, new_rdy;
        if (rst_i || clear_i) begin
            model_reset();
            return;
        end
        idle    = !m_job && !m_fin;
        start   = idle && start_i && m_rdy;
        new_rdy = idle && (k_ready_i || k_idle_i);
        if (start) sbq.push_back(snap(0));
        if (m_fin) sbq.push_back(snap(1));
        if (start) begin
            m_job = 1; m_len = int'(len_i); m_err = 0; m_kflag = 0;
            m_pc = 0; m_ps = 0;
            for (int c = 0; c < N_OUT; c++) m_oc[c] = 0;
            for (int c = 0; c < N_IN; c++) m_ic[c] = 0;
        end else if (m_job) begin
            all_done = 1;
            for (int c = 0; c < N_OUT; c++) if (m_oc[c] != m_len) all_done = 0;
            finish = all_done && (m_kflag || k_done_i);
            stall  = 0;
            for (int c = 0; c < N_OUT; c++) begin
                if (out_valid_i[c] && !out_ready_i[c]) stall = 1;
                if (out_valid_i[c] && out_ready_i[c]) begin
                    if (m_oc[c] == m_len) m_err = 1;
                    else m_oc[c] = m_oc[c] + 1;
                end
            end
            for (int c = 0; c < N_IN; c++)
                if (in_valid_i[c] && in_ready_i[c]) m_ic[c] = (m_ic[c] + 1) % 256;
            if (k_done_i) m_kflag = 1;
            if (m_pc < CMAX) m_pc++;
            if (stall && m_ps < CMAX) m_ps++;
            if (finish) begin m_job = 0; m_fin = 1; end
        end else if (m_fin) begin
            m_fin = 0;
        end
        m_rdy = new_rdy;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        if (!rst_i && (k_start_o || done_o)) begin
            ev_t e;
            int  kind;
            kind = done_o ? 1 : 0;
            if (k_start_o) n_start++;
            if (done_o) n_done++;
            if (sbq.size() == 0) begin
                chk("unexpected_pulse_kind", kind, -1);
            end else begin
                e = sbq.pop_front();
                chk("ev_kind", kind, e.kind);
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_out_cnt", out_cnt_o, e.ocnt);
                chk("ev_in_cnt", in_cnt_o, e.icnt);
                chk("ev_err", err_o, e.err);
                chk("ev_perf_cyc", perf_cyc_o, e.pc);
                chk("ev_perf_stall", perf_stall_o, e.ps);
                chk("ev_busy", busy_o, 0);
                if (kind == 0) chk("ev_ready_at_start", ready_o, 1);
                chk("ev_both_pulses", k_start_o & done_o, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        model_eval();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        start_i = 0; clear_i = 0; k_done_i = 0;
        in_valid_i = '0; in_ready_i = '0; out_valid_i = '0; out_ready_i = '0;
    endtask

    task automatic idle_cycles(input int n);
        quiet();
        repeat (n) step();
    endtask

    task automatic begin_job(input int len);
        quiet();
        start_i = 1; len_i = CNT_W'(len);
        step();
        start_i = 0;
    endtask

    task automatic beats(input logic [N_OUT-1:0] ch, input int n);
        quiet();
        out_valid_i = ch; out_ready_i = ch;
        in_valid_i = '1; in_ready_i = '1;
        repeat (n) step();
        quiet();
    endtask

    task automatic kdone();
        quiet();
        k_done_i = 1;
        step();
        k_done_i = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;
        rst_i = 1; k_ready_i = 1; k_idle_i = 0; len_i = '0;
        quiet();
        model_reset();
        step(); step();
        chk("rst_k_start", k_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_out_cnt", out_cnt_o, 0);
        chk("rst_in_cnt", in_cnt_o, 0);
        chk("rst_strb", strb_o, 8'hFF);
        chk("rst_perf_cyc", perf_cyc_o, 0);
        chk("rst_perf_stall", perf_stall_o, 0);
        rst_i = 0;
        step();
        chk("ready_after_lag", ready_o, 1);

        // two outputs, len 4, kernel done after the last beat
        s0 = n_start; d0 = n_done;
        begin_job(4);
        chk("t1_busy", busy_o, 1);
        beats(2'b11, 4);
        kdone();
        idle_cycles(3);
        chk("t1_starts", n_start - s0, 1);
        chk("t1_dones", n_done - d0, 1);
        chk("t1_out_cnt", out_cnt_o, 16'h0404);
        chk("t1_err", err_o, 0);

        // len 3, kernel done early
        d0 = n_done;
        begin_job(3);
        kdone();
        beats(2'b01, 3);
        chk("t2_still_busy", busy_o, 1);
        beats(2'b10, 3);
        idle_cycles(3);
        chk("t2_dones", n_done - d0, 1);
        chk("t2_out_cnt", out_cnt_o, 16'h0303);

        // len 2, overrun on channel 0
        d0 = n_done;
        begin_job(2);
        beats(2'b01, 2);
        chk("t3_err_before", err_o, 0);
        beats(2'b01, 1);
        chk("t3_err_after", err_o, 1);
        chk("t3_cnt0_held", out_cnt_o[7:0], 2);
        beats(2'b10, 2);
        kdone();
        idle_cycles(3);
        chk("t3_dones", n_done - d0, 1);
        chk("t3_err_sticky", err_o, 1);

        // start while not ready, then start mid-job
        s0 = n_start; d0 = n_done;
        k_ready_i = 0; k_idle_i = 0;
        idle_cycles(2);
        start_i = 1; len_i = 5;
        step();
        chk("t4_no_busy", busy_o, 0);
        k_ready_i = 1;
        idle_cycles(1);
        begin_job(2);
        quiet();
        start_i = 1; len_i = 7;
        out_valid_i = '1; out_ready_i = '1;
        step(); step();
        quiet();
        kdone();
        idle_cycles(3);
        chk("t4_starts", n_start - s0, 1);
        chk("t4_dones", n_done - d0, 1);
        chk("t4_out_cnt", out_cnt_o, 16'h0202);

        // clear in WAIT together with kernel done
        d0 = n_done;
        begin_job(1);
        beats(2'b11, 1);
        idle_cycles(2);
        chk("t5_wait_busy", busy_o, 1);
        clear_i = 1; k_done_i = 1;
        step();
        quiet();
        chk("t5_busy", busy_o, 0);
        chk("t5_out_cnt", out_cnt_o, 0);
        chk("t5_in_cnt", in_cnt_o, 0);
        idle_cycles(3);
        chk("t5_dones", n_done - d0, 0);

        // performance counters: 10 active cycles, 3 stalls on channel 1
        d0 = n_done;
        begin_job(1);
        quiet(); out_valid_i = 2'b10;
        repeat (3) step();
        beats(2'b11, 1);
        idle_cycles(5);
        kdone();
        idle_cycles(3);
        chk("t6_dones", n_done - d0, 1);
        chk("t6_perf_cyc", perf_cyc_o, PERF ? 10 : 0);
        chk("t6_perf_stall", perf_stall_o, PERF ? 3 : 0);

        // reset mid-job
        d0 = n_done;
        begin_job(3);
        beats(2'b11, 1);
        rst_i = 1;
        step();
        chk("t7_busy", busy_o, 0);
        chk("t7_out_cnt", out_cnt_o, 0);
        rst_i = 0;
        idle_cycles(3);
        chk("t7_dones", n_done - d0, 0);

        // long job: input counters wrap, perf counters saturate
        begin_job(255);
        quiet();
        in_valid_i = '1; in_ready_i = '1; out_valid_i = 2'b10;
        repeat (300) step();
        quiet();
        chk("t8_in_wrap", in_cnt_o, 16'h2C2C);
        chk("t8_perf_cyc_sat", perf_cyc_o, PERF ? 255 : 0);
        chk("t8_perf_stall_sat", perf_stall_o, PERF ? 255 : 0);
        clear_i = 1;
        step();
        quiet();
        chk("t8_clear_in_cnt", in_cnt_o, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start_i     = ($urandom % 6) == 0;
            len_i       = CNT_W'($urandom % 5);
            k_ready_i   = ($urandom % 4) != 0;
            k_idle_i    = $urandom % 2;
            k_done_i    = ($urandom % 10) == 0;
            clear_i     = ($urandom % 150) == 0;
            in_valid_i  = N_IN'($urandom);
            in_ready_i  = N_IN'($urandom);
            out_valid_i = N_OUT'($urandom);
            out_ready_i = N_OUT'($urandom);
            step();
        end
        idle_cycles(5);
        chk("sb_drained", sbq.size(), 0);
        chk("random_jobs_seen", (n_done > 10) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
